// File: rtl/fetch_seq_pkg.sv
// Shared types and constants for the SEQ core fetch sequencer.
package fetch_seq_pkg;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_HOLD = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

  localparam logic [31:0] INSTR_BYTES  = 32'd4;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DEF_TRAP_VEC = 32'h0000_0100;

endpackage

// File: rtl/fetch_sequencer_next_pc.sv
// Combinational next-PC computation for an accepted instruction.
module next_pc_calc
  import fetch_seq_pkg::*;
(
  input  logic [31:0] instr_pc,
  input  logic        branch,
  input  logic        alu_zero,
  input  logic [63:0] imm,
  output logic [31:0] target,
  output logic        misaligned
);

  // Only the low word of the immediate can reach a 32-bit PC.
  logic unused_imm_hi_s;
  assign unused_imm_hi_s = ^imm[63:32];

  // Select taken-branch or sequential target, both modulo 2^32
  always_comb begin
    if (branch && alu_zero) begin
      target = instr_pc + (imm[31:0] << 1'b1);
    end else begin
      target = instr_pc + INSTR_BYTES;
    end
  end

  assign misaligned = (target[1:0] != 2'b00);

endmodule

// File: rtl/fetch_sequencer.sv
// Program counter and single-outstanding imem fetch handshake for the SEQ core.
module fetch_sequencer
  import fetch_seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter logic [31:0] TRAP_VEC = DEF_TRAP_VEC
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        branch,
  input  logic        alu_zero,
  input  logic [63:0] imm,
  input  logic        trap,
  input  logic        resume,
  output logic        misalign,
  output logic        halted
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  instr_pc_q, instr_pc_d;
  logic         instr_valid_q, instr_valid_d;
  logic         misalign_q, misalign_d;
  logic         squash_q, squash_d;
  logic [31:0]  target_s;
  logic         target_misaligned_s;

  next_pc_calc u_next_pc (
    .instr_pc   (instr_pc_q),
    .branch     (branch),
    .alu_zero   (alu_zero),
    .imm        (imm),
    .target     (target_s),
    .misaligned (target_misaligned_s)
  );

  // Next-state and datapath selection for the fetch FSM
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    misalign_d    = misalign_q;
    squash_d      = squash_q;
    case (state_q)
      ST_REQ: begin
        if (imem_ack) begin
          if (trap || squash_q) begin
            // Response belongs to a fetch made stale by a trap: drop it.
            pc_d     = TRAP_VEC;
            squash_d = 1'b0;
          end else begin
            instr_d       = imem_rdata;
            instr_pc_d    = pc_q;
            instr_valid_d = 1'b1;
            state_d       = ST_HOLD;
          end
        end else begin
          // Request must stay stable until acked, so defer the redirect.
          if (trap) begin
            squash_d = 1'b1;
          end else begin
            squash_d = squash_q;
          end
        end
      end
      ST_HOLD: begin
        if (trap) begin
          pc_d          = TRAP_VEC;
          instr_valid_d = 1'b0;
          state_d       = ST_REQ;
        end else if (instr_valid_q && instr_ready) begin
          instr_valid_d = 1'b0;
          if (target_misaligned_s) begin
            misalign_d = 1'b1;
            state_d    = ST_HALT;
          end else begin
            pc_d    = target_s;
            state_d = ST_REQ;
          end
        end else begin
          state_d = ST_HOLD;
        end
      end
      ST_HALT: begin
        if (resume) begin
          misalign_d = 1'b0;
          pc_d       = TRAP_VEC;
          state_d    = ST_REQ;
        end else begin
          state_d = ST_HALT;
        end
      end
      default: begin
        state_d       = ST_REQ;
        instr_valid_d = 1'b0;
      end
    endcase
  end

  // FSM state and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_REQ;
      pc_q          <= RESET_PC;
      instr_q       <= 32'd0;
      instr_pc_q    <= 32'd0;
      instr_valid_q <= 1'b0;
      misalign_q    <= 1'b0;
      squash_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      misalign_q    <= misalign_d;
      squash_q      <= squash_d;
    end
  end

  // Gating with reset drops the request the moment reset asserts.
  assign imem_req    = (state_q == ST_REQ) && !reset;
  assign imem_addr   = pc_q;
  assign instr_valid = instr_valid_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign misalign    = misalign_q;
  assign halted      = (state_q == ST_HALT);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Table-driven cycle-by-cycle check of fetch_sequencer plus an async-reset sequence.
module tb_fetch_sequencer;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        branch;
  logic        alu_zero;
  logic [63:0] imm;
  logic        trap;
  logic        resume;
  logic        misalign;
  logic        halted;

  int n_pass  = 0;
  int n_total = 0;

  fetch_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready),
    .branch      (branch),
    .alu_zero    (alu_zero),
    .imm         (imm),
    .trap        (trap),
    .resume      (resume),
    .misalign    (misalign),
    .halted      (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One row per clock cycle: inputs driven that cycle, outputs expected that cycle.
  typedef struct packed {
    logic        ack;
    logic [31:0] rdata;
    logic        ready;
    logic        br;
    logic        z;
    logic [63:0] imm;
    logic        trap;
    logic        resume;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_ipc;
    logic        e_mis;
    logic        e_halt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t rq(input logic [31:0] addr, input logic ack,
                              input logic [31:0] rdata, input logic tr);
    vec_t v;
    v = '0;
    v.ack = ack; v.rdata = rdata; v.trap = tr;
    v.e_req = 1'b1; v.e_addr = addr;
    return v;
  endfunction

  function automatic vec_t hd(input logic [31:0] ipc, input logic [31:0] ins,
                              input logic rdy, input logic br, input logic z,
                              input logic [63:0] im, input logic tr);
    vec_t v;
    v = '0;
    v.ready = rdy; v.br = br; v.z = z; v.imm = im; v.trap = tr;
    v.e_valid = 1'b1; v.e_instr = ins; v.e_ipc = ipc;
    return v;
  endfunction

  function automatic vec_t hl(input logic tr, input logic res);
    vec_t v;
    v = '0;
    v.trap = tr; v.resume = res;
    v.e_mis = 1'b1; v.e_halt = 1'b1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    imem_ack    = v.ack;
    imem_rdata  = v.rdata;
    instr_ready = v.ready;
    branch      = v.br;
    alu_zero    = v.z;
    imm         = v.imm;
    trap        = v.trap;
    resume      = v.resume;
  endtask

  initial begin
    vec_t idle;
    idle = '0;
    drive(idle);
    reset = 1'b1;

    // Straight-line fetch: ack on the third REQ cycle, immediate ready.
    tbl.push_back(rq(32'h0, 1'b0, 32'h0, 1'b0));
    tbl.push_back(rq(32'h0, 1'b0, 32'h0, 1'b0));
    tbl.push_back(rq(32'h0, 1'b1, 32'hA000_0000, 1'b0));
    tbl.push_back(hd(32'h0, 32'hA000_0000, 1'b1, 1'b0, 1'b0, 64'h0, 1'b0));
    tbl.push_back(rq(32'h4, 1'b0, 32'h0, 1'b0));
    tbl.push_back(rq(32'h4, 1'b0, 32'h0, 1'b0));
    tbl.push_back(rq(32'h4, 1'b1, 32'hA000_0001, 1'b0));
    tbl.push_back(hd(32'h4, 32'hA000_0001, 1'b1, 1'b0, 1'b0, 64'h0, 1'b0));
    tbl.push_back(rq(32'h8, 1'b0, 32'h0, 1'b0));
    tbl.push_back(rq(32'h8, 1'b0, 32'h0, 1'b0));
    tbl.push_back(rq(32'h8, 1'b1, 32'hA000_0002, 1'b0));
    // 8 + (0x1C<<1) = 0x40
    tbl.push_back(hd(32'h8, 32'hA000_0002, 1'b1, 1'b1, 1'b1, 64'h1C, 1'b0));
    tbl.push_back(rq(32'h40, 1'b1, 32'hB000_0000, 1'b0));
    // 0x40 + (-8<<1) = 0x30
    tbl.push_back(hd(32'h40, 32'hB000_0000, 1'b1, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0));
    tbl.push_back(rq(32'h30, 1'b1, 32'hB000_0001, 1'b0));
    tbl.push_back(hd(32'h30, 32'hB000_0001, 1'b1, 1'b1, 1'b1, 64'h8, 1'b0));
    tbl.push_back(rq(32'h40, 1'b1, 32'hB000_0002, 1'b0));
    // Branch not taken: 0x44
    tbl.push_back(hd(32'h40, 32'hB000_0002, 1'b1, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0));
    tbl.push_back(rq(32'h44, 1'b1, 32'hC000_0000, 1'b0));
    for (int k = 0; k < 10; k++) begin
      tbl.push_back(hd(32'h44, 32'hC000_0000, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0));
    end
    // Upper imm bits ignored: 0x44 + (-26<<1) = 0x10
    tbl.push_back(hd(32'h44, 32'hC000_0000, 1'b1, 1'b1, 1'b1, 64'h1234_5678_FFFF_FFE6, 1'b0));
    tbl.push_back(rq(32'h10, 1'b1, 32'hD000_0000, 1'b0));
    // 0x10 + 2 = 0x12 is misaligned
    tbl.push_back(hd(32'h10, 32'hD000_0000, 1'b1, 1'b1, 1'b1, 64'h1, 1'b0));
    tbl.push_back(hl(1'b1, 1'b0));
    tbl.push_back(hl(1'b0, 1'b0));
    tbl.push_back(hl(1'b0, 1'b1));
    tbl.push_back(rq(32'h100, 1'b1, 32'hE000_0000, 1'b0));
    tbl.push_back(hd(32'h100, 32'hE000_0000, 1'b1, 1'b0, 1'b0, 64'h0, 1'b0));
    // Trap while the fetch of 0x104 is pending, ack three cycles later
    tbl.push_back(rq(32'h104, 1'b0, 32'h0, 1'b1));
    tbl.push_back(rq(32'h104, 1'b0, 32'h0, 1'b0));
    tbl.push_back(rq(32'h104, 1'b0, 32'h0, 1'b0));
    tbl.push_back(rq(32'h104, 1'b1, 32'hDEAD_BEEF, 1'b0));
    tbl.push_back(rq(32'h100, 1'b0, 32'h0, 1'b0));
    tbl.push_back(rq(32'h100, 1'b1, 32'hE000_0001, 1'b0));
    // Trap in HOLD overrides a simultaneous taken branch
    tbl.push_back(hd(32'h100, 32'hE000_0001, 1'b1, 1'b1, 1'b1, 64'h4, 1'b1));
    // Trap coinciding with ack discards the data
    tbl.push_back(rq(32'h100, 1'b1, 32'hE000_0002, 1'b1));
    tbl.push_back(rq(32'h100, 1'b1, 32'hE000_0003, 1'b0));
    // 0x100 + (0x7FFFFF7E<<1 mod 2^32) = 0xFFFF_FFFC
    tbl.push_back(hd(32'h100, 32'hE000_0003, 1'b1, 1'b1, 1'b1, 64'h0000_0000_7FFF_FF7E, 1'b0));
    tbl.push_back(rq(32'hFFFF_FFFC, 1'b1, 32'hF000_0000, 1'b0));
    tbl.push_back(hd(32'hFFFF_FFFC, 32'hF000_0000, 1'b1, 1'b0, 1'b0, 64'h0, 1'b0));
    tbl.push_back(rq(32'h0, 1'b1, 32'hF000_0001, 1'b0));
    tbl.push_back(hd(32'h0, 32'hF000_0001, 1'b1, 1'b0, 1'b0, 64'h0, 1'b0));
    tbl.push_back(rq(32'h4, 1'b0, 32'h0, 1'b0));

    repeat (2) @(negedge clk);
    chk("rst.req",      {31'd0, imem_req},    32'd0);
    chk("rst.valid",    {31'd0, instr_valid}, 32'd0);
    chk("rst.instr",    instr,                32'd0);
    chk("rst.instr_pc", instr_pc,             32'd0);
    chk("rst.misalign", {31'd0, misalign},    32'd0);
    chk("rst.halted",   {31'd0, halted},      32'd0);
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i]);
      #1;
      chk($sformatf("r%0d.req", i),      {31'd0, imem_req},    {31'd0, tbl[i].e_req});
      chk($sformatf("r%0d.valid", i),    {31'd0, instr_valid}, {31'd0, tbl[i].e_valid});
      chk($sformatf("r%0d.misalign", i), {31'd0, misalign},    {31'd0, tbl[i].e_mis});
      chk($sformatf("r%0d.halted", i),   {31'd0, halted},      {31'd0, tbl[i].e_halt});
      if (tbl[i].e_req) begin
        chk($sformatf("r%0d.addr", i), imem_addr, tbl[i].e_addr);
      end else begin
        chk($sformatf("r%0d.addr_idle", i), {31'd0, imem_req}, 32'd0);
      end
      if (tbl[i].e_valid) begin
        chk($sformatf("r%0d.instr", i),    instr,    tbl[i].e_instr);
        chk($sformatf("r%0d.instr_pc", i), instr_pc, tbl[i].e_ipc);
      end else begin
        chk($sformatf("r%0d.novalid", i), {31'd0, instr_valid}, 32'd0);
      end
      @(negedge clk);
    end

    // Async reset mid-REQ (addr 0x4 pending): request drops without a clock edge.
    drive(idle);
    #1;
    chk("ar.pre_req",  {31'd0, imem_req}, 32'd1);
    chk("ar.pre_addr", imem_addr,         32'h4);
    #1 reset = 1'b1;
    #1;
    chk("ar.req_drop", {31'd0, imem_req},    32'd0);
    chk("ar.valid",    {31'd0, instr_valid}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("ar.refetch_req",  {31'd0, imem_req}, 32'd1);
    chk("ar.refetch_addr", imem_addr,         32'h0);
    imem_ack   = 1'b1;
    imem_rdata = 32'h1357_9BDF;
    @(negedge clk);
    drive(idle);
    #1;
    chk("ar.hold_valid", {31'd0, instr_valid}, 32'd1);
    chk("ar.hold_instr", instr,                32'h1357_9BDF);
    chk("ar.hold_pc",    instr_pc,             32'h0);
    chk("ar.hold_noreq", {31'd0, imem_req},    32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Controls the program counter and the instruction-memory fetch handshake for the SEQ core.
- Issues one fetch at a time to imem and holds the returned instruction until the core accepts it.
- Computes the next PC from the branch/zero-flag resolution of the accepted instruction.
- Handles trap redirects, misaligned-target faults and a halt/resume state.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- TRAP_VEC, 32'h0000_0100, PC loaded on trap or resume.

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- imem_req  out  1  fetch request, held until imem_ack
- imem_addr  out  32  fetch address, stable while imem_req=1
- imem_ack  in  1  fetch complete; imem_rdata valid this cycle
- imem_rdata  in  32  fetched instruction word
- instr_valid  out  1  instr/instr_pc valid
- instr  out  32  held instruction
- instr_pc  out  32  PC of held instruction
- instr_ready  in  1  core accepts held instruction this cycle
- branch  in  1  held instruction is a branch (sampled on accept)
- alu_zero  in  1  branch condition (sampled on accept)
- imm  in  64  sign-extended immediate (sampled on accept)
- trap  in  1  redirect to TRAP_VEC
- resume  in  1  leave HALT
- misalign  out  1  sticky misaligned-target fault
- halted  out  1  state==HALT

Behaviour:
- States are REQ, HOLD and HALT. All outputs are registered or decoded from registered state.
- Reset: state=REQ, pc=RESET_PC, instr/instr_pc=0, instr_valid=0, misalign=0, squash=0.
  - imem_req=1 with imem_addr=RESET_PC in the first cycle after reset deasserts.
  - Reset mid-transaction abandons it immediately. imem must tolerate this.
- REQ:
  - imem_req=1 and imem_addr=pc.
  - On imem_ack with squash=0: instr<=imem_rdata, instr_pc<=pc, go HOLD. instr_valid=1 next cycle.
  - On imem_ack with squash=1: discard data, clear squash, stay REQ at the new pc.
  - Zero-wait ack (in the same cycle req rises) is legal.
- HOLD:
  - instr_valid=1, imem_req=0. Waits indefinitely for instr_ready.
  - On instr_valid&instr_ready, compute the next PC:
    - If branch&alu_zero: target = instr_pc + (imm[31:0]<<1), modulo 2^32 (upper imm bits ignored).
    - Otherwise: target = instr_pc + 4, wrapping 32'hFFFF_FFFC -> 0.
  - If target[1:0]!=0: misalign<=1, go HALT, pc unchanged, instr_valid<=0.
  - Otherwise: pc<=target, go REQ, instr_valid<=0.
- Trap (highest priority, any state except HALT):
  - pc<=TRAP_VEC.
  - In HOLD: instr_valid<=0 and the accept/branch is ignored that cycle; go REQ.
  - In REQ without ack: the request is never withdrawn and the address is not changed. Set squash=1; the pending response is discarded, then fetch TRAP_VEC.
  - In REQ with ack in the same cycle: data discarded, next cycle REQ at TRAP_VEC.
- HALT:
  - imem_req=0, instr_valid=0, halted=1. trap is ignored.
  - On resume: misalign<=0, pc<=TRAP_VEC, go REQ.
- Throughput: 2 cycles per instruction minimum (REQ+HOLD) with zero-wait imem and immediate ready.

Decomposition:
- Package fetch_seq_pkg holds:
  - the state enum (REQ, HOLD, HALT);
  - INSTR_BYTES=4;
  - default RESET_PC and TRAP_VEC constants.
- Sub-module next_pc_calc (combinational) takes instr_pc, branch, alu_zero and imm. It outputs target[31:0] and misaligned.

Test Plan:
- Reset release, imem ack after 2 cycles, instr_ready immediate:
  - imem_addr sequence 0,4,8.
  - instr_pc matches each fetch.
  - instr_valid low during REQ.
- Accepted instr at instr_pc=0x40 with branch=1, alu_zero=1, imm=64'hFFFF_FFFF_FFFF_FFF8:
  - next imem_addr=0x30.
  - With alu_zero=0: next imem_addr=0x44.
- Branch at instr_pc=0x10 with imm=1:
  - target=0x12, so misalign=1 and halted=1; no further imem_req.
  - resume -> misalign=0, imem_addr=0x100.
- Trap while imem_req is pending (ack 3 cycles later with rdata=0xDEADBEEF):
  - imem_addr unchanged until the ack.
  - rdata dropped; instr_valid stays 0.
  - next imem_addr=0x100.
- instr_ready held low for 10 cycles in HOLD:
  - instr_valid, instr and instr_pc stable.
  - imem_req stays 0.
- instr_pc=0xFFFF_FFFC, no branch:
  - next imem_addr=0x0.
  - Async reset asserted mid-REQ -> imem_req=0 immediately, then refetch RESET_PC.
